bus_rr_scheduler: RTL
=====================

# bus_rr_scheduler

Round-robin scheduler that shares the common packet bus between `drvrs` device FIFOs. Each cycle of service it grants one pending FIFO, pops one `pckg_sz`-bit packet, decodes the destination ID in the packet header and pushes the packet into the destination device (or all other devices on broadcast). It sits between the per-device FIFOs fed by the drivers and the device receive ports, and is the DUT the agent/driver/checker environment exercises.

## Interface
- `drvrs`, 4: number of devices on the bus, 2..16.
- `pckg_sz`, 40: packet width in bits, ≥ 16.
- `broadcast`, 8'hFF: destination ID meaning "all devices except the source".

- `clk`  in  1  bus clock, all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `pndng`  in  `drvrs`  bit i high means FIFO i is non-empty.
- `D_pop`  in  `drvrs` x `pckg_sz`  head packet of each FIFO, show-ahead (valid while `pndng[i]`).
- `pop`  out  `drvrs`  one-hot, 1-cycle pop strobe to FIFO i.
- `D_push`  out  `pckg_sz`  packet broadcast to all device inputs.
- `push`  out  `drvrs`  push strobe per device, qualifies `D_push`.
- `gnt_id`  out  `$clog2(drvrs)`  index of the currently or last granted FIFO.
- `busy`  out  1  high in GRANT and DELIVER.
- `drop_cnt`  out  16  saturating count of dropped packets.

## Operation
- Packet format: `[pckg_sz-1 -: 8]` destination ID; the rest is payload, passed untouched.
- FSM states: IDLE, GRANT, DELIVER.
- IDLE: if `|pndng`, pick the first requester searching `last+1, last+2, …` with wrap modulo `drvrs`. Register the pick into `gnt_id` and go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - If `pndng[gnt_id]` is still high: assert `pop[gnt_id]`, capture `D_pop[gnt_id]` into the packet register, set `last = gnt_id`, go to DELIVER.
  - If `pndng[gnt_id]` has dropped: no pop, `last` is unchanged, return to IDLE (abort).
- DELIVER: drive `D_push` = captured packet, then decode the destination `dst`:
  - `dst == broadcast`: push to every device except `gnt_id`.
  - `dst < drvrs` and `dst != gnt_id`: `push[dst]` only.
  - Otherwise (self-addressed or out of range): no push; `drop_cnt` increments, saturating at 16'hFFFF.
  - Always return to IDLE after DELIVER.
- `pndng` changes in GRANT or DELIVER are ignored, except for the GRANT abort check above.

## Timing
- Reset values: `pop=0`, `push=0`, `D_push=0`, `gnt_id=0`, `busy=0`, `drop_cnt=0`, state IDLE, `last=drvrs-1` (so the first grant goes to FIFO 0).
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous). A pop already done in that GRANT is not replayed, and the packet is lost.
- Latency:
  - Edge 0 samples `pndng` in IDLE.
  - Cycle 1: GRANT, `pop` high.
  - Cycle 2: DELIVER, `push` high.
  - Cycle 3: IDLE.
  - Throughput is one packet per 3 cycles; continuous requesters are served back-to-back with no extra idle cycle beyond IDLE.
- Strobe widths: `pop` and `push` are registered outputs, high for exactly one cycle each. At most one `pop` bit is ever high.
- `D_push` holds its last value outside DELIVER; devices use `push` only.
- Fairness: with all FIFOs pending, each FIFO is granted once every `3*drvrs` cycles.

## Structure
- Shared package `bus_pkg`:
  - `ID_W = 8`
  - `BROADCAST_ID`
  - `typedef enum {IDLE, GRANT, DELIVER} sched_state_e`
  - Header field helper for extracting the destination.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are `req[drvrs]` and `last`; outputs are `any` and `idx`. It is reusable by later multi-bus variants.
- The top level holds the FSM, packet register, `last` pointer, push decode and drop counter.

## Test plan
1. Reset, then idle with `pndng=0` for 20 cycles → every output stays at its reset value; `busy=0`.
2. `pndng=4'b0010`, `D_pop[1]=40'h02_0000_00AB` → cycle 1: `pop=4'b0010`, `gnt_id=1`; cycle 2: `push=4'b0100`, `D_push=40'h02_0000_00AB`.
3. All four FIFOs hold `pndng` high for 15 cycles, each addressing a valid other device → `pop` order is 0,1,2,3,0, spaced 3 cycles apart.
4. FIFO 3 sends `40'hFF_1234_5678` → `push=4'b0111` for one cycle.
5. FIFO 2 sends dest 8'h02 and then dest 8'h09 → no `push` for either; `drop_cnt` goes 0→1→2.
6. Two stimuli:
   - Drop `pndng[0]` in the cycle before GRANT → no `pop`, return to IDLE.
   - Assert `rst_n=0` during DELIVER → `push` clears asynchronously, and the next grant goes to FIFO 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the packet-bus scheduler family.
//   ID_W          : width of the destination ID field in the packet header
//   BROADCAST_ID  : destination meaning "every device except the source"
//   PKT_MAX       : widest packet the header helper accepts
//   sched_state_e : scheduler FSM states
//   hdr_dst()     : extracts the destination ID from the top byte of a packet
package bus_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
    localparam int PKT_MAX = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2
    } sched_state_e;

    // The destination sits in the top ID_W bits of a pkt_w-wide packet.
    // Callers zero-extend their packet to PKT_MAX bits.
    function automatic logic [ID_W-1:0] hdr_dst(input logic [PKT_MAX-1:0] pkt,
                                               input int pkt_w);
        return pkt[pkt_w-1 -: ID_W];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req  : request vector, one bit per requester
//   last : index of the most recently served requester
//   any  : at least one request is present
//   idx  : first requester found searching last+1, last+2, ... modulo N
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Walk the offsets from farthest to nearest so the nearest hit after
    // 'last' is the one left standing when the loop ends.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            logic [IDX_W-1:0] w_cand;
            w_cand = IDX_W'((int'(last) + k) % N);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler sharing one packet bus between drvrs device FIFOs.
// One packet is moved every three cycles: IDLE picks a requester, GRANT pops
// its FIFO and captures the head packet, DELIVER presents the packet with the
// push strobes for its destination(s).
//   clk, rst_n   : bus clock, asynchronous active-low reset
//   pndng        : per-FIFO non-empty flags
//   D_pop        : per-FIFO show-ahead head packet
//   pop          : one-hot pop strobe, high during GRANT
//   D_push       : captured packet, held between deliveries
//   push         : per-device push strobes qualifying D_push, high in DELIVER
//   gnt_id       : current or most recent granted FIFO
//   busy         : scheduler is in GRANT or DELIVER
//   drop_cnt     : saturating count of self-addressed / out-of-range packets
//   o_dbg_state  : current FSM state
// Handshake: a FIFO pops its head on the rising edge that ends a cycle in
// which pop[i] is high; a device accepts D_push on the rising edge that ends
// a cycle in which its push[i] is high. There is no back-pressure.
module bus_rr_scheduler
    import bus_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 40,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID,
    localparam int             IDX_W     = $clog2(drvrs)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [pckg_sz-1:0]              D_push,
    output logic [drvrs-1:0]                push,
    output logic [IDX_W-1:0]                gnt_id,
    output logic                            busy,
    output logic [15:0]                     drop_cnt,
    output sched_state_e                    o_dbg_state
);

    sched_state_e         r_state;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_gnt;
    logic [drvrs-1:0]     r_pop;
    logic [drvrs-1:0]     r_push;
    logic [pckg_sz-1:0]   r_pkt;
    logic [15:0]          r_drop;

    logic                 w_any;
    logic [IDX_W-1:0]     w_pick;
    logic [drvrs-1:0]     w_pick_oh;
    logic [drvrs-1:0]     w_push_mask;

    // Push targets for a packet coming from FIFO src. An all-zero result
    // means the packet is dropped.
    function automatic logic [drvrs-1:0] push_mask(input logic [pckg_sz-1:0] pkt,
                                                   input logic [IDX_W-1:0]   src);
        logic [ID_W-1:0]  dst;
        logic [drvrs-1:0] src_oh;
        logic [drvrs-1:0] mask;
        dst         = hdr_dst(PKT_MAX'(pkt), pckg_sz);
        src_oh      = '0;
        src_oh[src] = 1'b1;
        mask        = '0;
        if (dst == broadcast) begin
            mask = ~src_oh;
        end else if ((int'(dst) < drvrs) && (dst != ID_W'(src))) begin
            mask[dst[IDX_W-1:0]] = 1'b1;
        end
        return mask;
    endfunction

    rr_pick #(
        .N     (drvrs),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (pndng),
        .last (r_last),
        .any  (w_any),
        .idx  (w_pick)
    );

    always_comb begin
        w_pick_oh         = '0;
        w_pick_oh[w_pick] = 1'b1;
    end

    assign w_push_mask = push_mask(D_pop[r_gnt], r_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= IDX_W'(drvrs - 1);
            r_gnt   <= '0;
            r_pop   <= '0;
            r_push  <= '0;
            r_pkt   <= '0;
            r_drop  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_pop   <= w_pick_oh;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_pop <= '0;
                    if (pndng[r_gnt]) begin
                        r_pkt   <= D_pop[r_gnt];
                        r_last  <= r_gnt;
                        r_push  <= w_push_mask;
                        r_state <= DELIVER;
                    end else begin
                        // Requester vanished between pick and pop: abort
                        // without moving the round-robin pointer.
                        r_state <= IDLE;
                    end
                end
                DELIVER: begin
                    r_push <= '0;
                    // An empty push mask in DELIVER is exactly a dropped packet.
                    if ((r_push == '0) && (r_drop != 16'hFFFF)) begin
                        r_drop <= r_drop + 16'd1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The registered pop is qualified by the live pndng flag so that a FIFO
    // emptying during GRANT is never popped (the abort case).
    assign pop         = r_pop & pndng;
    assign push        = r_push;
    assign D_push      = r_pkt;
    assign gnt_id      = r_gnt;
    assign busy        = (r_state != IDLE);
    assign drop_cnt    = r_drop;
    assign o_dbg_state = r_state;

endmodule
